// File: rtl/seg7_display_driver.sv
// seg7_display_driver: frame-synchronous 8-digit hex driver for a multiplexed active-low 7-segment display.
// Optional leading-zero blanking is enabled with `define SEG_LEAD_ZERO_BLANK_EN.
module seg7_display_driver #(
   parameter int DIGIT_PERIOD = 100000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        IOWrite,
   input  logic [31:0] IO_output,
   output logic [31:0] display_value,
   output logic [7:0]  seg_en,
   output logic [7:0]  seg_out
);
   localparam int CW = $clog2(DIGIT_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(DIGIT_PERIOD - 1);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [31:0]   pending;
   logic          pending_valid;
   logic          wrap, frame_end, blank_digit;
   logic [3:0]    nibble;
   logic [7:0]    next_en, next_out;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'hC0;
         4'h1: hex7 = 8'hF9;
         4'h2: hex7 = 8'hA4;
         4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;
         4'h5: hex7 = 8'h92;
         4'h6: hex7 = 8'h82;
         4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;
         4'h9: hex7 = 8'h90;
         4'hA: hex7 = 8'h88;
         4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;
         4'hD: hex7 = 8'hA1;
         4'hE: hex7 = 8'h86;
         default: hex7 = 8'h8E;
      endcase
   endfunction

   assign wrap      = cnt == LAST;
   assign frame_end = wrap && idx == 3'd7;
   assign nibble    = display_value[{idx, 2'b00} +: 4];

`ifdef SEG_LEAD_ZERO_BLANK_EN
   logic [2:0] msd;
   // msd stays 0 for an all-zero word so digit 0 still shows "0"
   always_comb begin
      msd = 3'd0;
      for (int i = 1; i < 8; i++)
         if (display_value[4*i +: 4] != 4'h0) msd = 3'(i);
   end
   assign blank_digit = idx > msd;
`else
   assign blank_digit = 1'b0;
`endif

   always_comb begin
      next_en  = (cnt == '0) ? 8'hFF : ~(8'b1 << idx);
      next_out = (cnt == '0 || blank_digit) ? 8'hFF : hex7(nibble);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt           <= '0;
         idx           <= 3'd0;
         pending       <= 32'h0;
         pending_valid <= 1'b0;
         display_value <= 32'h0;
         seg_en        <= 8'hFF;
         seg_out       <= 8'hFF;
      end else begin
         cnt     <= wrap ? '0 : cnt + 1'b1;
         idx     <= wrap ? idx + 3'd1 : idx;
         seg_en  <= next_en;
         seg_out <= next_out;
         if (frame_end) begin
            display_value <= IOWrite ? IO_output : (pending_valid ? pending : display_value);
            pending_valid <= 1'b0;
         end else if (IOWrite) begin
            pending       <= IO_output;
            pending_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver: randomized scoreboard bench against a time-based reference model (DIGIT_PERIOD=4).
module tb_seg7_display_driver;
   localparam int P = 4;
   localparam int FRAME = 8 * P;

   logic        clock = 1'b0;
   logic        reset;
   logic        IOWrite;
   logic [31:0] IO_output;
   logic [31:0] display_value;
   logic [7:0]  seg_en, seg_out;

   seg7_display_driver #(.DIGIT_PERIOD(P)) dut (
      .clock(clock), .reset(reset), .IOWrite(IOWrite), .IO_output(IO_output),
      .display_value(display_value), .seg_en(seg_en), .seg_out(seg_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] d;
      logic [7:0]  e;
      logic [7:0]  o;
   } exp_t;
   exp_t q[$];

   logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   int          mc;
   logic [31:0] mdisp, mpend;
   logic        mpv;
   int          checks = 0, errors = 0;
   logic        seen_111 = 1'b0, seen_1234 = 1'b0;

   // reference: scan position derived from elapsed cycles since reset, not from counters
   initial forever begin
      exp_t x;
      int slot, pos, top;
      @(posedge clock);
      if (reset) begin
         mc = 0; mdisp = 0; mpend = 0; mpv = 0;
         x = '{32'h0, 8'hFF, 8'hFF};
      end else begin
         pos  = mc % P;
         slot = (mc / P) % 8;
         top  = 0;
         for (int i = 0; i < 8; i++) if (((mdisp >> (4*i)) & 32'hF) != 0) top = i;
         x.e = (pos == 0) ? 8'hFF : ~(8'h01 << slot);
         x.o = (pos == 0) ? 8'hFF : hex_tab[(mdisp >> (4*slot)) & 32'hF];
`ifdef SEG_LEAD_ZERO_BLANK_EN
         if (pos != 0 && slot > top) x.o = 8'hFF;
`endif
         if (mc % FRAME == FRAME - 1) begin
            if (IOWrite) mdisp = IO_output;
            else if (mpv) mdisp = mpend;
            mpv = 0;
         end else if (IOWrite) begin
            mpend = IO_output;
            mpv = 1;
         end
         x.d = mdisp;
         mc++;
      end
      q.push_back(x);
   end

   initial forever begin
      exp_t x;
      @(posedge clock);
      #1;
      if (display_value == 32'h11111111) seen_111 = 1'b1;
      if (display_value == 32'h1234ABCD) seen_1234 = 1'b1;
      if (q.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard empty at %0t", $time);
      end else begin
         x = q.pop_front();
         checks += 3;
         if (display_value !== x.d) begin errors++; $display("FAIL display_value got %h exp %h at %0t", display_value, x.d, $time); end
         if (seg_en !== x.e) begin errors++; $display("FAIL seg_en got %h exp %h at %0t", seg_en, x.e, $time); end
         if (seg_out !== x.o) begin errors++; $display("FAIL seg_out got %h exp %h at %0t", seg_out, x.o, $time); end
      end
   end

   task automatic write_at(input int p, input logic [31:0] d);
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clock);
         if (mc % FRAME == p) break;
      end
      IOWrite = 1'b1; IO_output = d;
      @(negedge clock);
      IOWrite = 1'b0;
   endtask

   initial begin
      reset = 1'b1; IOWrite = 1'b0; IO_output = 32'h0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (2 * FRAME) @(negedge clock);
      write_at(13, 32'h1234ABCD);
      repeat (2 * FRAME) @(negedge clock);
      write_at(3, 32'h11111111);
      write_at(9, 32'h22222222);
      repeat (2 * FRAME) @(negedge clock);
      write_at(FRAME - 1, 32'hFFFFFFFF);
      repeat (2 * FRAME) @(negedge clock);
      write_at(21, 32'h55555555);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2 * FRAME) @(negedge clock);
      write_at(5, 32'h000000A5);
      repeat (2 * FRAME) @(negedge clock);
      write_at(7, 32'h0);
      repeat (2 * FRAME) @(negedge clock);
      repeat (600) begin
         @(negedge clock);
         IOWrite   = $urandom_range(0, 9) == 0;
         IO_output = $urandom >> $urandom_range(0, 31);
         reset     = $urandom_range(0, 199) == 0;
      end
      @(negedge clock);
      IOWrite = 1'b0; reset = 1'b0;
      repeat (2 * FRAME) @(negedge clock);
      checks += 2;
      if (seen_111) begin errors++; $display("FAIL overwritten_word got seen exp never"); end
      if (!seen_1234) begin errors++; $display("FAIL commit_1234ABCD got never exp seen"); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg7_display_driver.md
# seg7_display_driver

Device-side consumer of the CPU's memory-mapped LED/display output word. The block captures every 32-bit word the CPU stores to the output port (IOWrite strobe plus data) and shows it as 8 hexadecimal digits on the board's multiplexed, active-low seven-segment display. New words are committed only at frame boundaries, so a frame never mixes digits from two different words.

## Interface
Parameters:
- DIGIT_PERIOD, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- IOWrite  in  1  one-cycle store strobe to the display/LED port
- IO_output  in  32  word being stored, sampled when IOWrite=1
- display_value  out  32  word currently committed to the display
- seg_en  out  8  digit enables, active-low; bit i = digit i, digit 0 rightmost
- seg_out  out  8  segments, active-low; {dp,g,f,e,d,c,b,a}

## Operation
Registers:
- pending [31:0] and pending_valid.
- display [31:0], driven on display_value.
- cnt, counting 0..DIGIT_PERIOD-1.
- idx [2:0].

Capture:
- IOWrite=1 → pending<=IO_output, pending_valid<=1.
- Back-to-back writes: the last one wins.

Scan:
- cnt increments every clock and wraps to 0 after DIGIT_PERIOD-1.
- On each cnt wrap, idx increments mod 8 (7→0).

Frame end is the cycle with idx=7 and cnt=DIGIT_PERIOD-1. At frame end:
- If IOWrite=1 in the same cycle: display<=IO_output, pending_valid<=0. The write wins and is committed directly.
- Else if pending_valid=1: display<=pending, pending_valid<=0.
- Else display holds.

Drive:
- Blank cycle (cnt=0 of every slot): seg_en=8'hFF, seg_out=8'hFF. This provides anti-ghosting.
- Other cycles: seg_en=~(8'b1<<idx), and seg_out = hex decode of display[4*idx+3:4*idx].
- dp is always off (bit7=1).
- Decode, active-low gfedcba with dp=1: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.

Reset, with registers cleared at the first rising edge where reset=1:
- display_value=0, seg_en=8'hFF, seg_out=8'hFF.
- cnt=0, idx=0, pending=0, pending_valid=0.
- Reset mid-frame discards any pending word.
- IOWrite is ignored while reset=1.

## Timing
- seg_en and seg_out are registered and lag the scan state (cnt, idx, display) by exactly one clock.
- First clock after reset deasserts: outputs show the blank state, since they are computed from cnt=0.
- Digit 0 is driven from the second clock after reset deassertion and stays driven for DIGIT_PERIOD-1 clocks.
- Each slot is one blank cycle followed by DIGIT_PERIOD-1 driven cycles. A full frame is 8×DIGIT_PERIOD clocks.
- Write-to-display_value latency: from 1 clock (write in the frame-end cycle) up to 8×DIGIT_PERIOD clocks.
- After display_value changes, seg_out reflects the new word from digit 0's first driven cycle of the next frame.
- No handshake and no backpressure: every IOWrite is accepted. Stores that are overwritten before frame end are never displayed.

## Configuration
Macro: SEG_LEAD_ZERO_BLANK_EN.
- Defined: during driven cycles, every digit above the most significant nonzero nibble of display outputs seg_out=8'hFF. seg_en is still asserted, which keeps brightness uniform. display=0 shows a single "0" on digit 0.
- Undefined: all 8 digits are always decoded, including leading zeros.

## Test plan
Benches use DIGIT_PERIOD=4.
- Reset held 3 cycles, then released → display_value=0, seg_en=FF and seg_out=FF on the first clock. On the next clock: seg_en=FE, seg_out=C0. Without the macro, seg_out=C0 on all 8 digits.
- Write 32'h1234ABCD mid-frame → display_value remains 0 until frame end, then equals 1234ABCD. The next frame shows digits 0..7 = A1,C6,83,88,99,B0,A4,F9 with a blank cycle before each.
- Two writes, 32'h11111111 then 32'h22222222, both in one frame → only 22222222 is ever committed; 11111111 never appears on display_value.
- Write 32'hFFFFFFFF on the exact frame-end cycle → display_value=FFFFFFFF one clock later, pending_valid=0, and the next frame shows 8E on every digit.
- Reset asserted with a pending write at idx=5 → display_value=0, pending discarded, scan restarts at digit 0, and nothing is committed at the next frame end.
- With SEG_LEAD_ZERO_BLANK_EN defined, write 32'h000000A5 → digit0=92, digit1=88, digits 2..7 seg_out=FF while their seg_en bit is low.
